nmea_checksum_checker: RTL and testbench
========================================

# nmea_checksum_checker

Byte-serial checksum verifier for NMEA sentences (GPZDA and siblings) arriving from the UART receiver. It XOR-accumulates every character between `$` and `*` and captures the two ASCII checksum characters that follow. It converts them to binary with a `HexParser` instance and reports match/mismatch or a framing error with a one-cycle `done` strobe. It sits between the UART RX byte stream and the field extractors, which act on a sentence only after `done && ok`.

## Interface

- `B`, 8: bits per character.
- `MAX_LEN`, 80: maximum number of body characters (between `$` and `*`, exclusive); must be ≥ 1.
- Reset is asynchronous and active-low on `rst_n`. The block uses one clock, `clk`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  B  received ASCII character; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per character. Back-to-back strobes are legal; there is no backpressure.
- `busy`  out  1  high while a sentence is open (any state except IDLE).
- `done`  out  1  one-cycle strobe: sentence finished or aborted.
- `ok`  out  1  valid while `done`=1: 1 means the checksum matched and `err`=0.
- `err`  out  2  error code, valid while `done`=1: 0 NONE, 1 BAD_HEX, 2 OVERFLOW, 3 TRUNCATED.
- `calc_sum`  out  B  computed XOR of the body; updated when `done` asserts, held until the next `done`.
- `rcv_sum`  out  B  parsed received checksum; updated when `done` asserts and held. It is 0 when `err`≠NONE.

## Operation

- The FSM has five states: IDLE, BODY, HEX_HI, HEX_LO, CHECK.
- In all states, bytes are processed only on `rx_valid`.
- **IDLE**
  - `$` → BODY, with `sum`=0 and `len`=0.
  - Any other character is ignored.
- **BODY**
  - `$`: `done` with TRUNCATED; `sum` and `len` are cleared; stay in BODY (resync).
  - `*` → HEX_HI.
  - CR (0x0D) or LF (0x0A): `done` with TRUNCATED → IDLE.
  - Any other character: `sum ^= rx_data` and `len++`.
  - If that increment makes `len` = MAX_LEN+1: `done` with OVERFLOW → IDLE.
- **HEX_HI / HEX_LO**
  - A character in `0`–`9` or `A`–`F` is stored as `hi_c` or `lo_c`. HEX_HI → HEX_LO; HEX_LO → CHECK.
  - `$`: `done` with TRUNCATED → BODY, cleared.
  - Any other character, including lowercase: `done` with BAD_HEX → IDLE.
- **CHECK**
  - This state always lasts exactly one cycle.
  - `HexParser` (B=B, L=1) combinationally converts `{hi_c, lo_c}`, with `hi_c` in the upper byte.
  - `ok` = (parsed == `sum`). `done`=1, `err`=NONE. `calc_sum` and `rcv_sum` are loaded.
  - Next state is IDLE.
  - If `rx_valid` is high with `$` during CHECK, the next state is BODY with `sum`/`len` cleared; any other byte during CHECK is dropped.
- `len` width is clog2(MAX_LEN+2). `sum` is B bits and wraps naturally under XOR.
- `$` and `*` are never included in `sum`.
- On any error `done`, `calc_sum` takes the partial `sum`.

## Timing

- Reset values:
  - state: IDLE.
  - `sum`, `len`, `hi_c`, `lo_c`: 0.
  - Outputs `busy`, `done`, `ok`: 0; `err`: 0; `calc_sum`, `rcv_sum`: 0.
- All outputs are registered.
- Error `done` is high in the cycle immediately after the cycle in which the offending byte had `rx_valid`=1.
- Normal `done` timing:
  - The low checksum character is presented in cycle n.
  - CHECK is the state during cycle n+1.
  - `done`, `ok`, `calc_sum`, and `rcv_sum` appear in cycle n+2.
- `done` is never high for two consecutive cycles unless two consecutive bytes each terminate a sentence.
- `busy` rises the cycle after `$` is accepted. It falls in the same cycle `done` rises when the next state is IDLE.
- Asserting reset mid-sentence discards the sentence and produces no `done`. The next `$` after release starts cleanly.

## Structure

- A shared header `nmea_defs.vh` holds:
  - character constants `CH_DOLLAR`, `CH_STAR`, `CH_CR`, `CH_LF`;
  - error codes `ERR_NONE`, `ERR_BAD_HEX`, `ERR_OVERFLOW`, `ERR_TRUNC`;
  - FSM state encodings.
- The only sub-module is one `HexParser` instance used for the checksum conversion.
- The hex-character validity check is a local function; it stays outside `HexParser`, which does not validate its input.

## Test plan

1. "$AB*03", one byte per cycle → `done` 2 cycles after `3`, `ok`=1, `err`=0, `calc_sum`=0x03, `rcv_sum`=0x03.
2. "$AB*04" → `ok`=0, `err`=0, `calc_sum`=0x03, `rcv_sum`=0x04.
3. "$A*4a" → after `a`: `done` with `err`=BAD_HEX, `ok`=0, `calc_sum`=0x41, `rcv_sum`=0; `busy` drops.
4. "$AB$A*41" → `done` with TRUNCATED after the second `$` (`calc_sum`=0x03), then `done` with `ok`=1 and `calc_sum`=0x41.
5. With MAX_LEN=4, "$ABCDE" → `done` with `err`=OVERFLOW the cycle after `E`; "*.." that follows is ignored in IDLE.
6. Reset asserted after "$AB*0" → no `done`, all outputs 0. Then "$A*41" with 3-cycle gaps between strobes → `ok`=1, `rcv_sum`=0x41.

Source files
------------

// File: rtl/nmea_checksum_checker_pkg.sv
// Shared character codes, error codes and FSM encoding for the NMEA checksum checker.
package nmea_checksum_checker_pkg;

    localparam logic [7:0] ChDollar = 8'h24;
    localparam logic [7:0] ChStar   = 8'h2A;
    localparam logic [7:0] ChCr     = 8'h0D;
    localparam logic [7:0] ChLf     = 8'h0A;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrBadHex   = 2'd1,
        ErrOverflow = 2'd2,
        ErrTrunc    = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        StIdle,
        StBody,
        StHexHi,
        StHexLo,
        StCheck
    } state_e;

endpackage

// File: rtl/nmea_checksum_checker_hex_parser.sv
// Combinational ASCII-hex to binary converter; input characters are assumed valid.
module nmea_checksum_checker_hex_parser #(
    parameter int unsigned B = 8,
    parameter int unsigned L = 1
) (
    input  logic [2*L*B-1:0] chars_i,
    output logic [8*L-1:0]   value_o
);

    // '0'-'9' carry their value in the low nibble; 'A'-'F' have bit 6 set and low nibble 1..6.
    function automatic logic [3:0] nibble(input logic [B-1:0] c);
        return c[6] ? (c[3:0] + 4'd9) : c[3:0];
    endfunction

    always_comb begin
        value_o = '0;
        for (int i = 0; i < 2 * L; i++) begin
            value_o[i*4 +: 4] = nibble(chars_i[i*B +: B]);
        end
    end

endmodule

// File: rtl/nmea_checksum_checker.sv
// Byte-serial NMEA sentence checksum verifier: XORs the body between '$' and '*',
// parses the two hex checksum characters and reports the outcome with a done strobe.
module nmea_checksum_checker
    import nmea_checksum_checker_pkg::*;
#(
    parameter int unsigned B       = 8,
    parameter int unsigned MAX_LEN = 80
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [B-1:0] rx_data_i,
    input  logic         rx_valid_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         ok_o,
    output logic [1:0]   err_o,
    output logic [B-1:0] calc_sum_o,
    output logic [B-1:0] rcv_sum_o
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 2);

    state_e          state_q, state_d;
    logic [B-1:0]    sum_q, sum_d;
    logic [LenW-1:0] len_q, len_d;
    logic [B-1:0]    hi_q, hi_d;
    logic [B-1:0]    lo_q, lo_d;

    logic            busy_q, done_q, ok_q;
    err_e            err_q;
    logic [B-1:0]    calc_q, rcv_q;

    logic            fin;
    logic            fin_ok;
    err_e            fin_err;
    logic [B-1:0]    fin_calc, fin_rcv;
    logic [7:0]      parsed_w;
    logic [B-1:0]    parsed;

    logic is_dollar, is_star, is_eol;

    function automatic logic is_hex(input logic [B-1:0] c);
        return ((c >= B'(8'h30)) && (c <= B'(8'h39))) ||
               ((c >= B'(8'h41)) && (c <= B'(8'h46)));
    endfunction

    nmea_checksum_checker_hex_parser #(
        .B(B),
        .L(1)
    ) u_hex_parser (
        .chars_i({hi_q, lo_q}),
        .value_o(parsed_w)
    );

    assign parsed    = B'(parsed_w);
    assign is_dollar = (rx_data_i == B'(ChDollar));
    assign is_star   = (rx_data_i == B'(ChStar));
    assign is_eol    = (rx_data_i == B'(ChCr)) || (rx_data_i == B'(ChLf));

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        len_d    = len_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        fin      = 1'b0;
        fin_ok   = 1'b0;
        fin_err  = ErrNone;
        fin_calc = sum_q;
        fin_rcv  = '0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid_i && is_dollar) begin
                    state_d = StBody;
                    sum_d   = '0;
                    len_d   = '0;
                end
            end
            StBody: begin
                if (rx_valid_i) begin
                    if (is_dollar) begin
                        // Resync: report the broken sentence and start a fresh one.
                        fin     = 1'b1;
                        fin_err = ErrTrunc;
                        sum_d   = '0;
                        len_d   = '0;
                    end else if (is_star) begin
                        state_d = StHexHi;
                    end else if (is_eol) begin
                        fin     = 1'b1;
                        fin_err = ErrTrunc;
                        state_d = StIdle;
                    end else begin
                        sum_d = sum_q ^ rx_data_i;
                        len_d = len_q + LenW'(1);
                        if (len_q == LenW'(MAX_LEN)) begin
                            fin      = 1'b1;
                            fin_err  = ErrOverflow;
                            fin_calc = sum_q ^ rx_data_i;
                            state_d  = StIdle;
                        end
                    end
                end
            end
            StHexHi, StHexLo: begin
                if (rx_valid_i) begin
                    if (is_hex(rx_data_i)) begin
                        if (state_q == StHexHi) begin
                            hi_d    = rx_data_i;
                            state_d = StHexLo;
                        end else begin
                            lo_d    = rx_data_i;
                            state_d = StCheck;
                        end
                    end else if (is_dollar) begin
                        fin     = 1'b1;
                        fin_err = ErrTrunc;
                        state_d = StBody;
                        sum_d   = '0;
                        len_d   = '0;
                    end else begin
                        fin     = 1'b1;
                        fin_err = ErrBadHex;
                        state_d = StIdle;
                    end
                end
            end
            StCheck: begin
                fin     = 1'b1;
                fin_ok  = (parsed == sum_q);
                fin_rcv = parsed;
                state_d = StIdle;
                if (rx_valid_i && is_dollar) begin
                    state_d = StBody;
                    sum_d   = '0;
                    len_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sum_q   <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= ErrNone;
            calc_q  <= '0;
            rcv_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= fin;
            if (fin) begin
                ok_q   <= fin_ok;
                err_q  <= fin_err;
                calc_q <= fin_calc;
                rcv_q  <= fin_rcv;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign ok_o       = ok_q;
    assign err_o      = err_q;
    assign calc_sum_o = calc_q;
    assign rcv_sum_o  = rcv_q;

endmodule

// File: tb/tb_nmea_checksum_checker.sv
// Randomised sentence generator with a scoreboard of expected done events, plus directed cases.
module tb_nmea_checksum_checker;

    localparam int unsigned MAX_LEN = 4;

    typedef struct {
        logic       ok;
        logic [1:0] err;
        logic [7:0] calc;
        logic [7:0] rcv;
    } ev_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       busy_o, done_o, ok_o;
    logic [1:0] err_o;
    logic [7:0] calc_sum_o, rcv_sum_o;

    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;
    int  sent_cyc = 0;
    bit  chk_en = 1'b0;
    ev_t exp_q[int];
    logic [7:0] last_calc = 8'h00;
    logic [7:0] last_rcv = 8'h00;

    nmea_checksum_checker #(
        .B(8),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .busy_o(busy_o),
        .done_o(done_o),
        .ok_o(ok_o),
        .err_o(err_o),
        .calc_sum_o(calc_sum_o),
        .rcv_sum_o(rcv_sum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Compare process: every cycle, done must match the scoreboard; sums hold between strobes.
    always begin
        @(posedge clk_i);
        cyc++;
        #2;
        if (chk_en) begin
            if (exp_q.exists(cyc)) begin
                chk("done", {31'd0, done_o}, 32'd1);
                chk("ok", {31'd0, ok_o}, {31'd0, exp_q[cyc].ok});
                chk("err", {30'd0, err_o}, {30'd0, exp_q[cyc].err});
                chk("calc_sum", {24'd0, calc_sum_o}, {24'd0, exp_q[cyc].calc});
                chk("rcv_sum", {24'd0, rcv_sum_o}, {24'd0, exp_q[cyc].rcv});
                last_calc = exp_q[cyc].calc;
                last_rcv  = exp_q[cyc].rcv;
                exp_q.delete(cyc);
            end else begin
                chk("no_done", {31'd0, done_o}, 32'd0);
                chk("calc_hold", {24'd0, calc_sum_o}, {24'd0, last_calc});
                chk("rcv_hold", {24'd0, rcv_sum_o}, {24'd0, last_rcv});
            end
        end
    end

    task automatic send(input logic [7:0] b, input int g);
        repeat (g) begin
            @(negedge clk_i);
            rx_valid = 1'b0;
        end
        @(negedge clk_i);
        rx_valid = 1'b1;
        rx_data  = b;
        sent_cyc = cyc;
    endtask

    task automatic send_str(input string s, input int g);
        for (int i = 0; i < s.len(); i++) send(s[i], g);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            rx_valid = 1'b0;
        end
    endtask

    task automatic expect_ev(input int at, input logic ok, input logic [1:0] err,
                             input logic [7:0] calc, input logic [7:0] rcv);
        ev_t e;
        e.ok = ok;
        e.err = err;
        e.calc = calc;
        e.rcv = rcv;
        exp_q[at] = e;
    endtask

    function automatic bit model_is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
    endfunction

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    function automatic logic [7:0] rnd_body();
        logic [7:0] c;
        do c = 8'($urandom_range(8'h20, 8'h7E)); while (c == 8'h24 || c == 8'h2A);
        return c;
    endfunction

    function automatic logic [7:0] rnd_nonhex();
        logic [7:0] c;
        do c = 8'($urandom_range(8'h20, 8'h7E)); while (model_is_hex(c) || c == 8'h24);
        return c;
    endfunction

    function automatic logic [7:0] rnd_noise();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'h24);
        return c;
    endfunction

    function automatic int gap();
        return int'($urandom_range(0, 2));
    endfunction

    // kind: 0 good, 1 wrong checksum, 2 bad hex, 3 overflow, 4 CR/LF, 5 '$' in body, 6 '$' in hex
    task automatic sentence(input int kind0);
        int kind = kind0;
        bit more = 1'b1;
        logic [7:0] s, c, rs;
        int n;
        send(8'h24, gap());
        while (more) begin
            more = 1'b0;
            s = 8'h00;
            n = (kind == 3) ? int'(MAX_LEN) + 1 : int'($urandom_range(0, MAX_LEN));
            for (int i = 0; i < n; i++) begin
                c = rnd_body();
                send(c, gap());
                s ^= c;
            end
            if (kind == 3) begin
                expect_ev(sent_cyc + 1, 1'b0, 2'd2, s, 8'h00);
            end else if (kind == 4) begin
                send(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, gap());
                expect_ev(sent_cyc + 1, 1'b0, 2'd3, s, 8'h00);
            end else if (kind == 5) begin
                send(8'h24, gap());
                expect_ev(sent_cyc + 1, 1'b0, 2'd3, s, 8'h00);
                kind = int'($urandom_range(0, 4));
                more = 1'b1;
            end else begin
                send(8'h2A, gap());
                if (kind == 0 || kind == 1) begin
                    rs = (kind == 0) ? s : (s ^ 8'($urandom_range(1, 255)));
                    send(to_hex(rs[7:4]), gap());
                    send(to_hex(rs[3:0]), gap());
                    expect_ev(sent_cyc + 2, rs == s, 2'd0, s, rs);
                end else begin
                    if ($urandom_range(0, 1) != 0) send(to_hex(4'($urandom_range(0, 15))), gap());
                    if (kind == 2) begin
                        send(rnd_nonhex(), gap());
                        expect_ev(sent_cyc + 1, 1'b0, 2'd1, s, 8'h00);
                    end else begin
                        send(8'h24, gap());
                        expect_ev(sent_cyc + 1, 1'b0, 2'd3, s, 8'h00);
                        kind = int'($urandom_range(0, 4));
                        more = 1'b1;
                    end
                end
            end
        end
        repeat ($urandom_range(0, 2)) send(rnd_noise(), gap());
    endtask

    initial begin
        int c;
        idle(3);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_ok", {31'd0, ok_o}, 32'd0);
        chk("rst_err", {30'd0, err_o}, 32'd0);
        chk("rst_calc", {24'd0, calc_sum_o}, 32'd0);
        chk("rst_rcv", {24'd0, rcv_sum_o}, 32'd0);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // 1: good sentence; busy rises the cycle after '$'
        send(8'h24, 0);
        send("A", 0);
        chk("busy_rise", {31'd0, busy_o}, 32'd1);
        send_str("B*03", 0);
        expect_ev(sent_cyc + 2, 1'b1, 2'd0, 8'h03, 8'h03);
        idle(4);

        // 2: checksum mismatch
        send_str("$AB*04", 0);
        expect_ev(sent_cyc + 2, 1'b0, 2'd0, 8'h03, 8'h04);
        idle(4);

        // 3: lowercase hex is rejected and busy drops with done
        send_str("$A*4a", 0);
        c = sent_cyc;
        expect_ev(c + 1, 1'b0, 2'd1, 8'h41, 8'h00);
        idle(1);
        chk("badhex_busy", {31'd0, busy_o}, 32'd0);
        idle(3);

        // 4: '$' inside the body truncates and resyncs
        send_str("$AB$", 0);
        expect_ev(sent_cyc + 1, 1'b0, 2'd3, 8'h03, 8'h00);
        send_str("A*41", 0);
        expect_ev(sent_cyc + 2, 1'b1, 2'd0, 8'h41, 8'h41);
        idle(4);

        // 5: overflow at MAX_LEN+1 body characters; trailing "*.." ignored in IDLE
        send_str("$ABCDE", 0);
        expect_ev(sent_cyc + 1, 1'b0, 2'd2, 8'h41, 8'h00);
        send_str("*..", 0);
        idle(4);

        // 6: reset mid-sentence discards it; restart with gaps
        send_str("$AB*0", 0);
        @(negedge clk_i);
        rx_valid = 1'b0;
        rst_ni = 1'b0;
        last_calc = 8'h00;
        last_rcv = 8'h00;
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_ok", {31'd0, ok_o}, 32'd0);
        chk("midrst_err", {30'd0, err_o}, 32'd0);
        chk("midrst_calc", {24'd0, calc_sum_o}, 32'd0);
        idle(2);
        rst_ni = 1'b1;
        idle(2);
        send_str("$A*41", 3);
        expect_ev(sent_cyc + 2, 1'b1, 2'd0, 8'h41, 8'h41);
        idle(4);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 200; i++) sentence(int'($urandom_range(0, 6)));
        idle(6);
        chk("pending_events", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
